// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD arithmetic blocks.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned BCD_BASE = 10;
  localparam int unsigned BCD_MAX  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_sub_state_t;

  function automatic logic bcd_digit_invalid(input bcd_digit_t x);
    return x > 4'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational one-digit BCD subtract with borrow; invalid digits pass through uncorrected.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       br_in,
  output bcd_digit_t diff,
  output logic       br_out
);

  logic [5:0] t;

  assign t = {2'b00, a} - {2'b00, b} - {5'b0_0000, br_in};

  // The difference lies in -16..15, so bits 5 and 4 both equal the sign.
  assign br_out = t[5] & t[4];
  assign diff   = t[5] ? (t[3:0] + 4'(BCD_BASE)) : t[3:0];

endmodule

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor D = A - B - Bin, LSD first, one digit per clock.
// Optional input-digit validity flag enabled by defining BCD_SUB_CHECK_EN.
module bcd_subtractor_serial
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] d,
  output logic                bout,
  output logic                err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

  bcd_sub_state_t state_q, state_d;

  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q, br_d;
  logic          bout_q, bout_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  bcd_digit_t    dig_diff;
  logic          dig_br;
  logic [W-1:0]  res_shift;
  logic          accept;
  logic          last_digit;

  assign accept     = (state_q == IDLE) && in_valid;
  assign last_digit = (cnt_q == LAST_IDX);
  assign res_shift  = W'({dig_diff, res_q} >> 4);

  bcd_digit_sub u_digit (
    .a      (a_sh_q[3:0]),
    .b      (b_sh_q[3:0]),
    .br_in  (br_q),
    .diff   (dig_diff),
    .br_out (dig_br)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    br_d        = br_q;
    bout_d      = bout_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_sh_d = a;
          b_sh_d = b;
          br_d   = bin;
          cnt_d  = '0;
          res_d  = '0;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 4;
        b_sh_d = b_sh_q >> 4;
        br_d   = dig_br;
        res_d  = res_shift;
        cnt_d  = cnt_q + CW'(1);
        if (last_digit) begin
          d_d    = res_shift;
          bout_d = dig_br;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      br_q        <= br_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef BCD_SUB_CHECK_EN
  logic any_bad;
  logic err_q, err_d;

  // Flag any non-decimal nibble in either operand at accept time
  always_comb begin
    any_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_digit_invalid(a[4*i +: 4]) || bcd_digit_invalid(b[4*i +: 4])) begin
        any_bad = 1'b1;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = any_bad;
    end else if ((state_q == DONE) && out_ready) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Self-checking bench for bcd_subtractor_serial against a decimal reference model.
module tb_bcd_subtractor_serial;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned W        = 4 * DIGITS;
  localparam int          N_RANDOM = 10000;

`ifdef BCD_SUB_CHECK_EN
  localparam logic ERR_ON_BAD = 1'b1;
`else
  localparam logic ERR_ON_BAD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] tb_a = '0;
  logic [W-1:0] tb_b = '0;
  logic         tb_bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] d;
  logic         bout;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (tb_a),
    .b         (tb_b),
    .bin       (tb_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int x);
    logic [W-1:0] r = '0;
    int y = x;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  task automatic ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                         output logic [W-1:0] dv, output logic boutv);
    int diff;
    diff  = bcd_to_int(av) - bcd_to_int(bv) - int'(binv);
    boutv = (diff < 0);
    if (diff < 0) diff = diff + 10 ** DIGITS;
    dv = int_to_bcd(diff);
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(9));
    return r;
  endfunction

  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
      n_fail++;
    end
    tb_a = av; tb_b = bv; tb_bin = binv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit rnd_ready, output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (rnd_ready) out_ready = ($urandom_range(3) != 0);
      tick();
      lat++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL wait_valid: out_valid=%b required 1", out_valid);
      n_fail++;
    end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] exp_d, input logic exp_bout,
                              input logic exp_err);
    n_checks++;
    if (d !== exp_d) begin
      $display("FAIL %s_d: got %h required %h", name, d, exp_d);
      n_fail++;
    end
    n_checks++;
    if (bout !== exp_bout) begin
      $display("FAIL %s_bout: got %b required %b", name, bout, exp_bout);
      n_fail++;
    end
    n_checks++;
    if (err !== exp_err) begin
      $display("FAIL %s_err: got %b required %b", name, err, exp_err);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b required 1", in_ready); n_fail++; end
    n_checks++;
    if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b required 0", out_valid); n_fail++; end
    check_result("reset", '0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b0;
    accept(16'h5432, 16'h1234, 1'b0);
    wait_valid(1'b0, lat);
    n_checks++;
    if (lat != int'(DIGITS) + 1) begin
      $display("FAIL basic_latency: got %0d required %0d", lat, DIGITS + 1);
      n_fail++;
    end
    check_result("basic", 16'h4198, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL basic_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      n_fail++;
    end
  endtask

  task automatic test_borrow();
    int lat;
    out_ready = 1'b1;
    accept(16'h0000, 16'h0001, 1'b0);
    wait_valid(1'b0, lat);
    check_result("borrow_wrap", 16'h9999, 1'b1, 1'b0);
    tick();
    accept(16'h1000, 16'h0999, 1'b1);
    wait_valid(1'b0, lat);
    check_result("borrow_chain", 16'h0000, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    accept(16'h0250, 16'h0731, 1'b1);
    wait_valid(1'b0, lat);
    for (int i = 0; i < 6; i++) begin
      tb_a = 16'h1111; tb_b = 16'h0000; in_valid = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b required 1 0", i, out_valid, in_ready);
        n_fail++;
      end
      check_result("bp_hold", 16'h9518, 1'b1, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    accept(16'h1234, 16'h0567, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL midreset: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      n_fail++;
    end
    repeat (4) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL midreset_discard: out_valid=%b required 0", out_valid);
        n_fail++;
      end
    end
    accept(16'h9999, 16'h9999, 1'b0);
    wait_valid(1'b0, lat);
    check_result("midreset_new", 16'h0000, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_invalid_digit();
    int lat;
    out_ready = 1'b1;
    accept(16'h00A0, 16'h0000, 1'b0);
    wait_valid(1'b0, lat);
    check_result("invalid", 16'h00A0, 1'b0, ERR_ON_BAD);
    tick();
    n_checks++;
    if (err !== 1'b0) begin
      $display("FAIL invalid_err_clear: got %b required 0", err);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int lat;
    logic [W-1:0] got_d = '0;
    logic got = 1'b0;
    out_ready = 1'b1;
    accept(16'h8001, 16'h0002, 1'b0);
    while (!in_ready && n < 40) begin
      if (out_valid) begin got_d = d; got = 1'b1; end
      tick();
      n++;
    end
    n_checks++;
    if (n + 1 != int'(DIGITS) + 2) begin
      $display("FAIL b2b_period: got %0d required %0d", n + 1, DIGITS + 2);
      n_fail++;
    end
    n_checks++;
    if (!got || got_d !== 16'h7999) begin
      $display("FAIL b2b_first_d: got %h (seen %b) required 7999", got_d, got);
      n_fail++;
    end
    accept(16'h0042, 16'h0017, 1'b1);
    wait_valid(1'b0, lat);
    check_result("b2b_second", 16'h0024, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, exp_d;
    logic binv, exp_bout;
    int lat;
    for (int k = 0; k < N_RANDOM; k++) begin
      av = rand_bcd();
      bv = rand_bcd();
      binv = 1'($urandom_range(1));
      ref_sub(av, bv, binv, exp_d, exp_bout);
      accept(av, bv, binv);
      wait_valid(1'b1, lat);
      n_checks++;
      if (lat != int'(DIGITS) + 1) begin
        $display("FAIL rand_latency: got %0d required %0d", lat, DIGITS + 1);
        n_fail++;
      end
      check_result("rand", exp_d, exp_bout, 1'b0);
      while (!out_ready) begin
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || d !== exp_d) begin
          $display("FAIL rand_stall: out_valid=%b d=%h required 1 %h", out_valid, d, exp_d);
          n_fail++;
        end
        out_ready = ($urandom_range(1) != 0);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_backpressure();
    test_reset_mid();
    test_invalid_digit();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_subtractor_serial.md
# bcd_subtractor_serial

Digit-serial packed-BCD subtractor: computes D = A − B − Bin over DIGITS decimal digits, one digit per clock, LSD first. It is the subtraction counterpart of the team's combinational BCD adder, used where decimal counters and displays need decrement or difference. Valid/ready on both sides; one operation in flight.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  4*DIGITS  minuend, packed BCD, digit 0 at [3:0]
- b  in  4*DIGITS  subtrahend, packed BCD
- bin  in  1  borrow in
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer accepts result
- d  out  4*DIGITS  difference, packed BCD (ten's complement mod 10^DIGITS when negative)
- bout  out  1  borrow out: 1 iff A < B + Bin
- err  out  1  invalid input digit flag (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture a, b, bin into shift registers; clear digit counter; go to RUN.
- RUN: each cycle process digit i (counter 0..DIGITS−1):
  - t = {2'b0,a_i} − {2'b0,b_i} − br, 6-bit two's complement.
  - t<0 → digit=(t+10)[3:0], br=1; else digit=t[3:0], br=0.
  - Shift digit into result register at MSD end; shift operands right by 4.
  - When counter==DIGITS−1: latch d, bout=br; go to DONE.
- DONE: out_valid=1; d, bout, err stable. On out_ready, go to IDLE, out_valid=0.
- Invalid digits (>9) are not corrected; the result follows the formula above exactly.
- in_valid while not in IDLE is ignored; a, b, and bin are sampled only at accept.
- Reset in any state: return to IDLE next cycle, discard the operation.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, d=0, bout=0, err=0, state=IDLE, counter=0.
- Accept at edge k. Digits are processed at edges k+1..k+DIGITS. out_valid is high from the cycle after edge k+DIGITS.
- Latency: DIGITS+1 cycles from accept to out_valid.
- If out_ready is high in the first out_valid cycle, the result is consumed at that edge and in_ready is high in the following cycle.
- Minimum accept-to-accept period: DIGITS+2 cycles.
- Outputs are registered. in_ready is decoded from state only, with no combinational path from in_valid or out_ready.
- Backpressure: DONE holds indefinitely with all outputs stable.

## Configuration
- BCD_SUB_CHECK_EN defined:
  - At accept, err_q is set if any digit of a or b is >9.
  - err is presented alongside out_valid and cleared on leaving DONE.
- Not defined: err is tied to 0 and the check logic is absent. Arithmetic is identical in both builds.

## Structure
- Package bcd_pkg holds:
  - typedef bcd_digit_t (logic [3:0])
  - constants BCD_BASE=10 and BCD_MAX=9
  - state enum bcd_sub_state_t {IDLE, RUN, DONE}
- Sub-module bcd_digit_sub: combinational one-digit subtract.
  - Inputs: a, b (bcd_digit_t), br_in.
  - Outputs: diff (bcd_digit_t), br_out.
  - Instantiated once, fed from the low nibble of the operand shift registers.

## Test plan
All scenarios use DIGITS=4.
- a=0x5432, b=0x1234, bin=0 → d=0x4198, bout=0; out_valid exactly 5 cycles after accept.
- a=0x0000, b=0x0001, bin=0 → d=0x9999, bout=1. a=0x1000, b=0x0999, bin=1 → d=0x0000, bout=0.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid → d/bout stable, in_ready=0, a second in_valid is ignored. Release → in_ready=1 next cycle.
- Assert rst for one cycle after 2 RUN digits → next cycle out_valid=0, in_ready=1. A new op a=0x9999, b=0x9999 → d=0x0000, bout=0.
- a=0x00A0, b=0x0000 → err=1 with BCD_SUB_CHECK_EN, err=0 without. d=0x00A0 in both builds.
- Random sweep of 10^4 valid operand pairs against a decimal reference model, with out_ready randomly toggled.
